// File: rtl/rv32ima_pkg.sv
// Shared types and constants for the CPU/RAM link memory-side responder.
package rv32ima_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RAM_IDLE,
    RAM_BUSY,
    RAM_DONE
  } ram_state_t;

  // Selects what ram_load presents: cleared after reset, the array word of the
  // last in-range read, or the poison word of the last out-of-range read.
  typedef enum logic [1:0] {
    LD_ZERO,
    LD_ARRAY,
    LD_BAD
  } load_src_t;

  localparam word_t RAM_BADDATA = 32'hBAD0_BAD0;
  localparam int    CNT_W       = 4;

endpackage

// File: rtl/ram_array.sv
// Synchronous single-port word array: write and registered read on the same edge.
module ram_array
  import rv32ima_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] idx_i,
  input  word_t            wdata_i,
  output word_t            rdata_o
);

  word_t mem_q [DEPTH];
  word_t rdata_q;

  // Storage write and read-data capture on the same clock edge.
  // NOTE: the array and its read register have no reset so they map onto RAM
  // macros; the responder masks rdata after reset via its load-source select.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// Memory-side end of the CPU/RAM link: accepts one request, waits LATENCY
// cycles, performs the access and pulses ram_ready for one cycle.
module ram_responder
  import rv32ima_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_store,
  input  logic        ram_ren,
  input  logic        ram_wen,
  output logic [31:0] ram_load,
  output logic        ram_ready,
  output logic        ram_err,
  output logic        ram_busy
);

  localparam int               IDX_W     = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(LATENCY - 1);
  localparam logic [29:0]      BASE_WORD = BASE_ADDR[31:2];

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("ram_responder: LATENCY=%0d outside 1..15", LATENCY);
  end

  ram_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [29:0]      waddr_q, waddr_d;
  word_t            wdata_q, wdata_d;
  logic             is_wr_q, is_wr_d;
  logic             err_q, err_d;
  load_src_t        ld_sel_q, ld_sel_d;

  logic             arr_we, arr_re;
  logic [29:0]      word_off;
  logic             oor;
  word_t            arr_rdata;
  logic             unused_addr_bits;

  // Byte-offset bits never reach the array; misaligned addresses act aligned.
  assign unused_addr_bits = ^ram_addr[1:0];

  // Decode always works on the latched address, so mid-flight input changes
  // cannot redirect the access.
  assign word_off = waddr_q - BASE_WORD;
  assign oor      = (waddr_q < BASE_WORD) || (word_off >= 30'(DEPTH));

  // State register and latched request; async active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= RAM_IDLE;
      cnt_q    <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      is_wr_q  <= 1'b0;
      err_q    <= 1'b0;
      ld_sel_q <= LD_ZERO;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      is_wr_q  <= is_wr_d;
      err_q    <= err_d;
      ld_sel_q <= ld_sel_d;
    end
  end

  // Next-state, counter, request latch and array strobes.
  // NOTE: every signal gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    is_wr_d  = is_wr_q;
    err_d    = err_q;
    ld_sel_d = ld_sel_q;
    arr_we   = 1'b0;
    arr_re   = 1'b0;
    unique case (state_q)
      RAM_IDLE: begin
        if (ram_ren || ram_wen) begin
          waddr_d = ram_addr[31:2];
          wdata_d = ram_store;
          is_wr_d = ram_wen;
          cnt_d   = CNT_INIT;
          state_d = RAM_BUSY;
        end
      end
      RAM_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          err_d   = oor;
          arr_we  = is_wr_q && !oor;
          arr_re  = !is_wr_q && !oor;
          if (!is_wr_q) ld_sel_d = oor ? LD_BAD : LD_ARRAY;
          state_d = RAM_DONE;
        end
      end
      RAM_DONE: state_d = RAM_IDLE;
      default:  state_d = RAM_IDLE;
    endcase
  end

  // Read-data source; holds the last read result until the next read.
  always_comb begin
    ram_load = '0;
    unique case (ld_sel_q)
      LD_ARRAY: ram_load = arr_rdata;
      LD_BAD:   ram_load = RAM_BADDATA;
      default:  ram_load = '0;
    endcase
  end

  assign ram_ready = (state_q == RAM_DONE);
  assign ram_busy  = (state_q == RAM_BUSY);
  assign ram_err   = ram_ready && err_q;

  ram_array #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_array (
    .clk    (CLK),
    .we_i   (arr_we),
    .re_i   (arr_re),
    .idx_i  (word_off[IDX_W-1:0]),
    .wdata_i(ram_store_q_unused_guard(wdata_q)),
    .rdata_o(arr_rdata)
  );

  function automatic word_t ram_store_q_unused_guard(input word_t w);
    return w;
  endfunction

endmodule

// File: tb/tb_ram_responder.sv
// Directed, table-driven bench for ram_responder with LATENCY=2, DEPTH=1024.
module tb_ram_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic        CLK;
  logic        nRST;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_load;
  logic        ram_ready;
  logic        ram_err;
  logic        ram_busy;

  int total = 0;
  int bad   = 0;

  ram_responder #(
    .DEPTH    (DEPTH),
    .LATENCY  (LATENCY),
    .BASE_ADDR(32'h0000_0000)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .ram_addr (ram_addr),
    .ram_store(ram_store),
    .ram_ren  (ram_ren),
    .ram_wen  (ram_wen),
    .ram_load (ram_load),
    .ram_ready(ram_ready),
    .ram_err  (ram_err),
    .ram_busy (ram_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] store;
    logic        ren;
    logic        wen;
    logic [31:0] exp_load;
    logic        exp_err;
    logic        chk_load;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, exp);
    end
  endtask

  // One request: drive after a rising edge, hold until ram_ready, then drop.
  // Returns the number of edges from accept to ready, the values seen with
  // ready, and ready/load one cycle later.
  task automatic txn(input string nm, input logic [31:0] a, input logic [31:0] s,
                     input logic r, input logic w, input logic scramble,
                     output int lat, output logic [31:0] load, output logic err,
                     output logic ready_after, output logic [31:0] load_after);
    logic got;
    @(posedge CLK); #1;
    ram_addr = a; ram_store = s; ram_ren = r; ram_wen = w;
    @(posedge CLK);
    lat = 0; got = 1'b0;
    @(negedge CLK);
    check({nm, " busy"}, {31'b0, ram_busy}, 32'd1);
    if (scramble) begin
      ram_addr  = 32'h0000_0300;
      ram_store = 32'h0BAD_F00D;
    end
    while (!got && lat < 20) begin
      if (ram_ready) got = 1'b1;
      else begin
        @(posedge CLK); lat++;
        @(negedge CLK);
      end
    end
    check({nm, " ready seen"}, {31'b0, got}, 32'd1);
    load = ram_load;
    err  = ram_err;
    check({nm, " busy low with ready"}, {31'b0, ram_busy}, 32'd0);
    ram_ren = 1'b0; ram_wen = 1'b0;
    @(negedge CLK);
    ready_after = ram_ready;
    load_after  = ram_load;
  endtask

  initial begin
    int          lat;
    logic [31:0] ld, ld_after;
    logic        er, rdy_after;

    //         addr          store         ren   wen   exp_load      err   chk
    vecs[0]  = '{32'h100,  32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0};
    vecs[1]  = '{32'h100,  32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF,1'b0, 1'b1};
    vecs[2]  = '{32'h040,  32'h1234,      1'b1, 1'b1, 32'h0,        1'b0, 1'b0};
    vecs[3]  = '{32'h040,  32'h0,         1'b1, 1'b0, 32'h1234,     1'b0, 1'b1};
    vecs[4]  = '{32'h000,  32'h11,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0};
    vecs[5]  = '{32'h1000, 32'h0,         1'b1, 1'b0, 32'hBAD0_BAD0,1'b1, 1'b1};
    vecs[6]  = '{32'h1000, 32'h55,        1'b0, 1'b1, 32'h0,        1'b1, 1'b0};
    vecs[7]  = '{32'h000,  32'h0,         1'b1, 1'b0, 32'h11,       1'b0, 1'b1};
    vecs[8]  = '{32'hFFC,  32'hA5A5,      1'b0, 1'b1, 32'h0,        1'b0, 1'b0};
    vecs[9]  = '{32'hFFF,  32'h0,         1'b1, 1'b0, 32'hA5A5,     1'b0, 1'b1};
    vecs[10] = '{32'h300,  32'h0,         1'b0, 1'b1, 32'h0,        1'b0, 1'b0};
    vecs[11] = '{32'h008,  32'h77,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0};

    nRST = 1'b0; ram_addr = '0; ram_store = '0; ram_ren = 1'b0; ram_wen = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset ready", {31'b0, ram_ready}, 32'd0);
    check("reset busy",  {31'b0, ram_busy},  32'd0);
    check("reset err",   {31'b0, ram_err},   32'd0);
    check("reset load",  ram_load,           32'd0);
    nRST = 1'b1;

    for (int i = 0; i < 12; i++) begin
      txn($sformatf("v%0d", i), vecs[i].addr, vecs[i].store, vecs[i].ren, vecs[i].wen,
          1'b0, lat, ld, er, rdy_after, ld_after);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(LATENCY));
      check($sformatf("v%0d err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      check($sformatf("v%0d ready pulse width", i), {31'b0, rdy_after}, 32'd0);
      if (vecs[i].chk_load) begin
        check($sformatf("v%0d load", i), ld, vecs[i].exp_load);
        check($sformatf("v%0d load held", i), ld_after, vecs[i].exp_load);
      end
    end

    // Inputs change mid-flight: the write must land at 0x200 with 0xCAFE.
    txn("scr wr", 32'h200, 32'hCAFE, 1'b0, 1'b1, 1'b1, lat, ld, er, rdy_after, ld_after);
    check("scr wr err", {31'b0, er}, 32'd0);
    txn("scr rd200", 32'h200, 32'h0, 1'b1, 1'b0, 1'b0, lat, ld, er, rdy_after, ld_after);
    check("scr rd200 load", ld, 32'hCAFE);
    txn("scr rd300", 32'h300, 32'h0, 1'b1, 1'b0, 1'b0, lat, ld, er, rdy_after, ld_after);
    check("scr rd300 load", ld, 32'h0);

    // Reset during a write to 0x8: write abandoned, outputs cleared, no pulse.
    @(posedge CLK); #1;
    ram_addr = 32'h8; ram_store = 32'h99; ram_wen = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("rst busy before", {31'b0, ram_busy}, 32'd1);
    nRST = 1'b0;
    #1;
    check("rst ready", {31'b0, ram_ready}, 32'd0);
    check("rst busy",  {31'b0, ram_busy},  32'd0);
    check("rst err",   {31'b0, ram_err},   32'd0);
    check("rst load",  ram_load,           32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check($sformatf("rst hold ready %0d", k), {31'b0, ram_ready}, 32'd0);
    end
    ram_wen = 1'b0; ram_addr = '0; ram_store = '0;
    nRST = 1'b1;
    txn("rst rd8", 32'h8, 32'h0, 1'b1, 1'b0, 1'b0, lat, ld, er, rdy_after, ld_after);
    check("rst rd8 load", ld, 32'h77);
    check("rst rd8 latency", 32'(lat), 32'(LATENCY));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
